// File: rtl/mcu0_pkg.sv
// mcu0_pkg: definitions shared by the mcu0 fetch and execute stages.
//   - opcode encodings (instruction bits [15:12])
//   - instruction field positions: OP = [15:12], C = [11:0]
//   - fetch FSM state encoding
//   - small field-extraction helpers
package mcu0_pkg;

  localparam logic [3:0] LD  = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] JMP = 4'h2;
  localparam logic [3:0] ST  = 4'h3;
  localparam logic [3:0] CMP = 4'h4;
  localparam logic [3:0] JEQ = 4'h5;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int C_HI  = 11;
  localparam int C_LO  = 0;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] instr_op(input logic [15:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [11:0] instr_c(input logic [15:0] instr);
    return instr[C_HI:C_LO];
  endfunction

endpackage

// File: rtl/mcu0_fetch.sv
// mcu0_fetch: instruction fetch stage feeding the mcu0 execute core.
// Reads big-endian 16-bit instructions one byte at a time from program
// memory (req/ack) and presents them with their address over valid/ready.
// A one-entry pend slot lets the next word be fetched while execute stalls.
// Ports:
//   clock        rising-edge clock
//   rst_n        asynchronous active-low reset
//   mem_req      byte read request
//   mem_addr     byte address (valid while mem_req=1)
//   mem_ack      transfer when mem_req & mem_ack
//   mem_rdata    read byte
//   ir_valid     ir/ir_pc hold a valid instruction
//   ir           instruction {byte@pc, byte@pc+1}
//   ir_pc        address of ir
//   ir_ready     execute consumes ir when ir_valid & ir_ready
//   redir_valid  flush and refetch from redir_pc
//   redir_pc     redirect target (bit 0 ignored)
module mcu0_fetch
  import mcu0_pkg::*;
#(
  parameter int unsigned     AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clock,
  input  logic          rst_n,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          ir_valid,
  output logic [15:0]   ir,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc
);

  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TWO = AW'(2);

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pend_pc;
  logic [7:0]    hi;
  logic [15:0]   pend;

  logic xfer;
  logic consume;
  logic out_free;

  // Gating with rst_n drops the request asynchronously on reset and lets it
  // rise in the very first cycle after release, without waiting for an edge.
  assign mem_req  = rst_n & (state != HOLD);
  assign mem_addr = (state == FETCH_LO) ? pc + ONE : pc;

  assign xfer     = mem_req & mem_ack;
  assign consume  = ir_valid & ir_ready;
  assign out_free = ~ir_valid | ir_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_HI;
      pc       <= RESET_PC;
      hi       <= '0;
      pend     <= '0;
      pend_pc  <= '0;
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
    end else if (redir_valid) begin
      // Redirect wins over everything: any byte arriving now is dropped and
      // a word parked in pend is simply abandoned.
      pc       <= redir_pc & ~ONE;
      state    <= FETCH_HI;
      ir_valid <= 1'b0;
    end else begin
      if (consume) ir_valid <= 1'b0;
      case (state)
        FETCH_HI: begin
          if (xfer) begin
            hi    <= mem_rdata;
            state <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (xfer) begin
            pc <= pc + TWO;
            if (out_free) begin
              ir       <= {hi, mem_rdata};
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              state    <= FETCH_HI;
            end else begin
              pend    <= {hi, mem_rdata};
              pend_pc <= pc;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            ir       <= pend;
            ir_pc    <= pend_pc;
            ir_valid <= 1'b1;
            state    <= FETCH_HI;
          end
        end
        default: state <= FETCH_HI;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Instructions are halfword aligned; an odd reset vector is a config error.
  always_ff @(posedge clock) begin
    assert (RESET_PC[0] == 1'b0)
      else $error("mcu0_fetch: RESET_PC must be even");
  end
`endif

endmodule

// File: tb/tb_mcu0_fetch.sv
module tb_mcu0_fetch;

  logic        clock = 1'b0;
  logic        rst_n;

  logic        mem_req, mem_ack, ir_valid, ir_ready, redir_valid;
  logic [15:0] mem_addr, ir, ir_pc, redir_pc;
  logic [7:0]  mem_rdata;

  logic        mem_req2, mem_ack2, ir_valid2, ir_ready2, redir_valid2;
  logic [15:0] mem_addr2, ir2, ir_pc2, redir_pc2;
  logic [7:0]  mem_rdata2;

  logic [7:0]  mem1 [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mcu0_fetch dut (
    .clock(clock), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc)
  );

  mcu0_fetch #(.AW(16), .RESET_PC(16'hFFFE)) dut2 (
    .clock(clock), .rst_n(rst_n),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
    .ir_valid(ir_valid2), .ir(ir2), .ir_pc(ir_pc2), .ir_ready(ir_ready2),
    .redir_valid(redir_valid2), .redir_pc(redir_pc2)
  );

  assign mem_rdata = mem1[mem_addr[7:0]];

  always_comb begin
    mem_rdata2 = 8'h00;
    case (mem_addr2)
      16'hFFFE: mem_rdata2 = 8'h21;
      16'hFFFF: mem_rdata2 = 8'h43;
      16'h0000: mem_rdata2 = 8'h65;
      16'h0001: mem_rdata2 = 8'h87;
      default:  mem_rdata2 = 8'h00;
    endcase
  end

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_iv;
    logic [15:0] e_ir;
    logic [15:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, ack, rdy, rv, input logic [15:0] rpc,
                     input logic req, input logic [15:0] addr, input logic iv,
                     input logic [15:0] irv, ipc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_ir = irv; v.e_ipc = ipc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [15:0] w_addr [5];
  logic        w_iv   [5];
  logic [15:0] w_ir   [5];
  logic [15:0] w_ipc  [5];
  int lat;

  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
    mem1[0] = 8'h00; mem1[1] = 8'h10; mem1[2] = 8'h10; mem1[3] = 8'h12;
    mem1[4] = 8'h20; mem1[5] = 8'h00; mem1[6] = 8'h30; mem1[7] = 8'h05;
    mem1[8] = 8'hAB; mem1[9] = 8'hCD;

    rst_n = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1; redir_valid = 1'b0; redir_pc = 16'h0;
    mem_ack2 = 1'b1; ir_ready2 = 1'b1; redir_valid2 = 1'b0; redir_pc2 = 16'h0;

    //   rst ack rdy rv rpc       req addr     iv ir        ir_pc
    // streaming, one instruction every 2 cycles
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1012, 16'h0002);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0005, 0, 16'h1012, 16'h0002);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h2000, 16'h0004);
    // memory stall in FETCH_LO at pc=2
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0010, 16'h0000);
    for (int k = 0; k < 5; k++)
      add(1, 0, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1012, 16'h0002);
    // execute back-pressure for 10 cycles, word parks in pend
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0010, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0010, 16'h0000);
    for (int k = 0; k < 6; k++)
      add(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h1012, 16'h0002);
    // redirect to 0x0009 during FETCH_LO at pc=4 with an ack
    add(1, 1, 1, 1, 16'h0009, 1, 16'h0005, 0, 16'h1012, 16'h0002);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0008, 0, 16'h1012, 16'h0002);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0009, 0, 16'h1012, 16'h0002);
    // redirect in the same cycle as an ir handshake
    add(1, 1, 1, 1, 16'h0002, 1, 16'h000A, 1, 16'hABCD, 16'h0008);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0002, 0, 16'hABCD, 16'h0008);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0003, 0, 16'hABCD, 16'h0008);
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1012, 16'h0002);
    // reset while FETCH_LO is stalled and ir_valid=1
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0005, 1, 16'h1012, 16'h0002);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 0, 16'h0000, 1, 16'h0002, 1, 16'h0010, 16'h0000);

    repeat (2) @(negedge clock);

    foreach (vecs[i]) begin
      @(negedge clock);
      rst_n = vecs[i].rst; mem_ack = vecs[i].ack; ir_ready = vecs[i].rdy;
      redir_valid = vecs[i].rv; redir_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d.ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d.ir", i), 32'(ir), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d.ir_pc", i), 32'(ir_pc), 32'(vecs[i].e_ipc));
    end

    // PC wrap-around on the RESET_PC=0xFFFE instance
    w_addr[0] = 16'hFFFE; w_iv[0] = 0; w_ir[0] = 16'h0000; w_ipc[0] = 16'h0000;
    w_addr[1] = 16'hFFFF; w_iv[1] = 0; w_ir[1] = 16'h0000; w_ipc[1] = 16'h0000;
    w_addr[2] = 16'h0000; w_iv[2] = 1; w_ir[2] = 16'h2143; w_ipc[2] = 16'hFFFE;
    w_addr[3] = 16'h0001; w_iv[3] = 0; w_ir[3] = 16'h2143; w_ipc[3] = 16'hFFFE;
    w_addr[4] = 16'h0002; w_iv[4] = 1; w_ir[4] = 16'h6587; w_ipc[4] = 16'h0000;
    @(negedge clock);
    rst_n = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1; redir_valid = 1'b0;
    #1;
    chk("wrap.reset_req", 32'(mem_req2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      rst_n = 1'b1;
      #1;
      chk($sformatf("wrap%0d.mem_req", k), 32'(mem_req2), 32'd1);
      chk($sformatf("wrap%0d.mem_addr", k), 32'(mem_addr2), 32'(w_addr[k]));
      chk($sformatf("wrap%0d.ir_valid", k), 32'(ir_valid2), 32'(w_iv[k]));
      if (w_iv[k]) begin
        chk($sformatf("wrap%0d.ir", k), 32'(ir2), 32'(w_ir[k]));
        chk($sformatf("wrap%0d.ir_pc", k), 32'(ir_pc2), 32'(w_ipc[k]));
      end
    end

    // latency from reset release to first ir_valid, bounded wait
    @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    #1;
    lat = 0;
    while (!ir_valid && lat < 10) begin
      @(negedge clock);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    chk("latency.ir", 32'(ir), 32'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
